// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - bus-mapped interrupt controller with per-source edge/level mode and masking
module irq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [WIDTH-1:0] irq_in,
  input  logic [31:0]      wb_dbus_adr,
  input  logic [31:0]      wb_dbus_dat,
  input  logic             wb_dbus_we,
  input  logic             cyc,
  output logic [31:0]      rdt,
  output logic             irq
);

  // Word offsets decoded from adr[4:2]
  localparam logic [2:0] SEL_STATUS  = 3'd0;
  localparam logic [2:0] SEL_ENABLE  = 3'd1;
  localparam logic [2:0] SEL_PENDING = 3'd2;
  localparam logic [2:0] SEL_MODE    = 3'd3;
  localparam logic [2:0] SEL_ID      = 3'd4;

  // Value returned by ID when nothing enabled is pending
  localparam logic [31:0] ID_NONE = 32'h8000_0000;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] enable_q, enable_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] mode_q, mode_d;
  logic             irq_q, irq_d;

  logic [2:0]       sel;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] active;
  logic             id_hit;
  logic [4:0]       id_idx;

  // Address and data bits outside the decoded/implemented range are intentionally ignored
  logic unused_bus_bits;
  assign unused_bus_bits = ^{wb_dbus_adr[31:5], wb_dbus_adr[1:0], wb_dbus_dat[31:WIDTH]};

  assign sel     = wb_dbus_adr[4:2];
  assign wr_en   = cyc & wb_dbus_we;
  assign rd_en   = cyc & ~wb_dbus_we;
  assign wr_data = wb_dbus_dat[WIDTH-1:0];

  // One-cycle-wide rising-edge detect on the first stage; a held-high line fires only once
  assign rise = s1_q & ~s2_q;

  // Write-one-to-clear mask, only meaningful for edge-mode bits
  assign clr_mask = (wr_en && (sel == SEL_PENDING)) ? wr_data : '0;

  // Sources that are both pending and unmasked drive irq and the ID lookup
  assign active = pending_q & enable_q;

  // Two-stage input pipeline: s1 is the sampled level, s2 its previous value
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= irq_in;
      s2_q <= s1_q;
    end
  end

  // Pending next state: edge bits set on rise (set beats clear), level bits track s1
  always_comb begin
    pending_d = (mode_q & (rise | (pending_q & ~clr_mask)))
              | (~mode_q & s1_q);
  end

  // Configuration registers load from the bus on a qualified write
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr_en) begin
      if (sel == SEL_ENABLE) begin
        enable_d = wr_data;
      end
      if (sel == SEL_MODE) begin
        mode_d = wr_data;
      end
    end
  end

  // irq reflects the pending/enable state as it stood before this edge
  always_comb begin
    irq_d = |active;
  end

  // State registers for configuration, pending and the CPU interrupt line
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  // Lowest-numbered active source wins; scanning downward leaves the lowest hit last
  always_comb begin
    id_hit = 1'b0;
    id_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (active[i]) begin
        id_hit = 1'b1;
        id_idx = 5'(i);
      end
    end
  end

  // Zero-wait-state read mux; idle, write and reset cycles return zero
  always_comb begin
    rdt = '0;
    if (!wb_rst && rd_en) begin
      case (sel)
        SEL_STATUS:  rdt = 32'(s1_q);
        SEL_ENABLE:  rdt = 32'(enable_q);
        SEL_PENDING: rdt = 32'(pending_q);
        SEL_MODE:    rdt = 32'(mode_q);
        SEL_ID:      rdt = id_hit ? {27'd0, id_idx} : ID_NONE;
        default:     rdt = '0;
      endcase
    end
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Bus-mapped interrupt controller that sits directly downstream of the timer and other peripherals. It collects their level interrupt lines, latches or follows each one per a mode bit, masks them, and drives the single `irq` input of the CPU. It is selected by a `chip_select` instance on the data bus, which supplies a one-cycle `cyc` strobe and generates `ack` itself. Reads and writes use the same bus conventions as the timer.

## Interface
Parameters:
- `WIDTH`, 8: number of interrupt sources, 1..31.

Ports:
- `wb_clk`, in, 1: single clock; all logic is on the rising edge.
- `wb_rst`, in, 1: asynchronous, active-high reset.
- `irq_in`, in, WIDTH: source lines. Bit 0 is the timer `irq`. All sources are synchronous to `wb_clk`.
- `wb_dbus_adr`, in, 32: bus address. Only bits [4:2] are decoded.
- `wb_dbus_dat`, in, 32: write data.
- `wb_dbus_we`, in, 1: write enable, qualified by `cyc`.
- `cyc`, in, 1: select strobe from `chip_select`, high for exactly one cycle per access.
- `rdt`, out, 32: read data. Valid while `cyc` is high and zero otherwise.
- `irq`, out, 1: registered interrupt request to the CPU.

## Operation
- Input stage:
  - `s1 <= irq_in` every cycle; `s2 <= s1` every cycle.
  - `rise = s1 & ~s2`.
- Register map (word offset = adr[4:2]). Bits at or above WIDTH read 0 and ignore writes.
  - 0x00 STATUS, RO: `s1`.
  - 0x04 ENABLE, RW: per-source mask.
  - 0x08 PENDING, R/W1C: pending bits.
  - 0x0C MODE, RW: 1 = rising-edge latched, 0 = level.
  - 0x10 ID, RO:
    - With at least one bit of `PENDING & ENABLE` set: the index of the lowest-numbered such bit, zero-extended, with bit 31 = 0.
    - With none set: returns 0x8000_0000.
  - Offsets 0x14–0x1C read 0, and writes to them are ignored.
- Pending update per bit i, each cycle:
  - Level mode (MODE[i]=0): `pending[i] <= s1[i]`. W1C has no effect.
  - Edge mode (MODE[i]=1):
    - `rise[i]` sets the bit.
    - A write with `cyc & we` to 0x08 and `dat[i]=1` clears it.
    - If a set and a clear occur in the same cycle, the set wins.
    - Otherwise the bit holds.
  - Changing MODE from 1 to 0 makes the bit follow the level from the next cycle. Changing from 0 to 1 keeps the current value until a clear.
- Output: `irq <= |(PENDING & ENABLE)`, using register values before the current edge's updates.
- Writes: on `cyc & we`, the addressed RW register loads `dat[WIDTH-1:0]` at the clock edge.
- Reads:
  - `rdt` is combinational from the current register values when `cyc & ~we`.
  - `rdt` is 0 whenever `cyc` is low, and 0 during a write cycle.
- Reset values: `s1`, `s2`, ENABLE, PENDING, MODE, `irq` and `rdt` are all 0. Reset mid-access aborts the access, and no register update occurs.

## Timing
- Interrupt latency from a source:
  - `irq_in` goes high before edge t0, so `s1` is high after t0.
  - PENDING is set after t1.
  - `irq` is high after t2 (edge or level mode, if enabled).
- Level source dropping:
  - `irq_in` low before t0, then PENDING clears after t1.
  - `irq` drops after t2.
- Bus writes:
  - ENABLE written at edge t sets `irq` to its new value after t+1.
  - A W1C at edge t drops `irq` after t+1, unless a new rising edge arrives in the same cycle.
- Read data: `rdt` has zero wait states inside the `cyc` cycle. PENDING/ID reads return the values from before that cycle's edge.
- Edge mode ignores a source held high: exactly one set per 0→1 transition of `s1`.

## Test plan
- Reset defaults:
  - Stimulus: assert `wb_rst` async mid-cycle with `irq_in`=0xFF.
  - Required response: `irq`=0, and `rdt`=0 outside `cyc`. After release, reads of 0x04/0x08/0x0C return 0, and a read of 0x10 returns 0x8000_0000.
- Level path with timer:
  - Stimulus: write ENABLE=0x01 and MODE=0, then raise `irq_in[0]` at t0.
  - Required response: `irq`=1 exactly after t2. Reading 0x10 returns 0. Dropping `irq_in[0]` drops `irq` two edges later. A W1C to 0x08 with 0x01 while the level is still high leaves `irq`=1.
- Edge latch and W1C:
  - Stimulus: write MODE=0x04 and ENABLE=0x04, then pulse `irq_in[2]` for one cycle.
  - Required response: PENDING reads 0x04 and `irq`=1 is held. Holding `irq_in[2]` high produces no re-set after a W1C of 0x04. A W1C then returns PENDING=0 and `irq`=0 one edge after the write.
- Simultaneous set and clear:
  - Stimulus: with bit 2 in edge mode and pending, issue a W1C 0x04 in the same cycle that a new rise of `rise[2]` occurs.
  - Required response: PENDING[2] remains 1 and `irq` stays 1.
- Masking and priority:
  - Stimulus: write MODE=0xFF, pulse `irq_in`=0x28, then write ENABLE=0x20.
  - Required response: PENDING=0x28, ID=5 and `irq`=1. Then writing ENABLE=0x08 gives ID=3, and writing ENABLE=0 gives `irq`=0 after one edge and ID=0x8000_0000.
- Out-of-range and width:
  - Stimulus: with WIDTH=8, write 0xFFFF_FFFF to 0x04, 0x0C and 0x18.
  - Required response: 0x04 and 0x0C read 0x0000_00FF, and 0x18 reads 0. `rdt`=0 on every cycle where `cyc` is low, checked throughout.
